// File: rtl/crc32_stream16.sv
// Streaming CRC-32 (reflected 0xEDB88320) over 16-bit beats with byte enables on the last beat.
// Each frame's result is held in an output register until the downstream consumer takes it.
module crc32_stream16 #(
    parameter logic [31:0] INIT   = 32'hFFFFFFFF,
    parameter logic [31:0] XOROUT = 32'hFFFFFFFF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    input  logic [15:0] s_data_i,
    input  logic [1:0]  s_keep_i,
    input  logic        s_last_i,
    output logic        crc_valid_o,
    input  logic        crc_ready_i,
    output logic [31:0] crc_o,
    output logic        crc_ok_o,
    output logic [15:0] frame_len_o
);

    localparam logic [31:0] POLY    = 32'hEDB88320;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_r;
    logic [31:0] crc_r;
    logic [15:0] len_r;

    logic        accept_s;
    logic [31:0] crc_base_s;
    logic [15:0] len_base_s;
    logic [31:0] crc_next_s;
    logic [16:0] len_inc_s;
    logic [16:0] len_sum_s;
    logic [15:0] len_next_s;

    // Bitwise CRC-32 step for one byte, least significant bit first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        end
        return c;
    endfunction

    // Two bytes per step; the low byte is earlier on the wire.
    function automatic logic [31:0] crc_word(input logic [31:0] crc, input logic [15:0] data);
        return crc_byte(crc_byte(crc, data[7:0]), data[15:8]);
    endfunction

    assign s_ready_o = ~crc_valid_o | crc_ready_i;
    assign accept_s  = s_valid_i & s_ready_o;

    // Next running CRC and saturating length for the beat currently offered.
    always_comb begin
        crc_base_s = (state_r == IDLE) ? INIT : crc_r;
        len_base_s = (state_r == IDLE) ? 16'h0000 : len_r;
        crc_next_s = crc_word(crc_base_s, s_data_i);
        len_inc_s  = 17'd2;
        if (s_last_i) begin
            case (s_keep_i)
                2'b01: begin
                    crc_next_s = crc_byte(crc_base_s, s_data_i[7:0]);
                    len_inc_s  = 17'd1;
                end
                2'b00: begin
                    crc_next_s = crc_base_s;
                    len_inc_s  = 17'd0;
                end
                default: begin
                    crc_next_s = crc_word(crc_base_s, s_data_i);
                    len_inc_s  = 17'd2;
                end
            endcase
        end else begin
            crc_next_s = crc_word(crc_base_s, s_data_i);
            len_inc_s  = 17'd2;
        end
        len_sum_s  = {1'b0, len_base_s} + len_inc_s;
        len_next_s = len_sum_s[16] ? 16'hFFFF : len_sum_s[15:0];
    end

    // Frame FSM, running state and the held result registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r     <= IDLE;
            crc_r       <= INIT;
            len_r       <= 16'h0000;
            crc_valid_o <= 1'b0;
            crc_o       <= 32'h00000000;
            crc_ok_o    <= 1'b0;
            frame_len_o <= 16'h0000;
        end else begin
            if (accept_s && s_last_i) begin
                // Preset immediately so the next frame can start on the following cycle.
                state_r     <= IDLE;
                crc_r       <= INIT;
                len_r       <= 16'h0000;
                crc_valid_o <= 1'b1;
                crc_o       <= crc_next_s ^ XOROUT;
                crc_ok_o    <= (crc_next_s == RESIDUE);
                frame_len_o <= len_next_s;
            end else if (accept_s) begin
                state_r <= BUSY;
                crc_r   <= crc_next_s;
                len_r   <= len_next_s;
                if (crc_valid_o && crc_ready_i) begin
                    crc_valid_o <= 1'b0;
                end else begin
                    crc_valid_o <= crc_valid_o;
                end
            end else begin
                if (crc_valid_o && crc_ready_i) begin
                    crc_valid_o <= 1'b0;
                end else begin
                    crc_valid_o <= crc_valid_o;
                end
            end
        end
    end

endmodule
